// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and counter sizing.
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } nsa_state_e;

  function automatic int nsa_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder; the single datapath reused every cycle by the serial adder.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams one nibble per cycle through a single 4-bit cla,
// LSB nibble first, with a registered carry between nibbles.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o
);
  localparam int N  = WIDTH / 4;
  localparam int CW = nsa_cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  nsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [3:0]       cla_sum;
  logic             cla_cout;

  cla u_cla (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // New nibble enters at the top so after N shifts the LSB nibble sits at [3:0].
  if (N == 1) begin : g_acc1
    assign acc_nxt = cla_sum;
  end else begin : g_accn
    assign acc_nxt = {cla_sum, acc_q[WIDTH-1:4]};
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_RUN;
        a_sh_d  = a_i;
        b_sh_d  = b_i;
        carry_d = cin_i;
        cnt_d   = '0;
        amsb_d  = a_i[WIDTH-1];
        bmsb_d  = b_i[WIDTH-1];
      end
      S_RUN: begin
        acc_d   = acc_nxt;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = cla_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          sum_d   = acc_nxt;
          cout_d  = cla_cout;
          ovf_d   = (amsb_q == bmsb_q) && (acc_nxt[WIDTH-1] != amsb_q);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = (state_q == S_RUN);
  assign done_o     = (state_q == S_DONE);
  assign sum_o      = sum_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed scoreboard bench: stimulus pushes expected {sum,cout,ovf}; monitor pops on done.
module tb_nibble_serial_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int errors = 0;
  int checks = 0;
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
    .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout), .overflow_o(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got sum=%h cout=%b ovf=%b expected no done", sum, cout, ovf);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        chk("result", {14'd0, sum, cout, ovf}, {14'd0, e});
      end
    end
  end

  task automatic wait_done(input string name);
    int lat = 0, bcnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 4);
    chk({name, "_busy_cycles"}, bcnt, 4);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    exp_q.push_back({es, ec, eo});
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(name);
    @(posedge clk); #1;  // DONE -> IDLE
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout_ovf", {cout, ovf}, 0);
    @(negedge clk); rst = 1'b0;

    run_op("basic",      16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("carrychain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("posovf",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("negovf",     16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("cin_prop",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Held start: operands changed during RUN/DONE must be ignored.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; start = 1'b1;
    exp_q.push_back({16'h1000, 1'b0, 1'b0});
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF;
    exp_q.push_back({16'hFFFE, 1'b1, 1'b0});
    wait_done("held");
    @(posedge clk); #1;
    chk("held_idle_gap_busy", busy, 0);
    @(posedge clk); #1;
    chk("held_reaccept_busy", busy, 1);
    start = 1'b0;
    wait_done("held2");
    @(posedge clk); #1;

    // Reset in the 2nd RUN cycle: outputs clear at once, no done.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout_ovf", {cout, ovf}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", done, 0);

    run_op("post_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
